// File: rtl/stump_control.sv
// Stump control unit: instruction decode, CC register, branch condition
// evaluation and the FETCH/EXECUTE/MEMORY sequencer.
module stump_control #(
    parameter logic [3:0] CC_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic [3:0]  flags_in,
    output logic [1:0]  state,
    output logic [2:0]  func,
    output logic        c_in,
    output logic [3:0]  cc,
    output logic        ext_op,
    output logic        opA_pc,
    output logic [2:0]  dest,
    output logic [2:0]  srcA,
    output logic [2:0]  srcB,
    output logic [1:0]  shift_op,
    output logic        reg_write,
    output logic        ir_load,
    output logic        pc_inc,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic        addr_alu
);

    localparam logic [1:0] S_FETCH   = 2'b00;
    localparam logic [1:0] S_EXECUTE = 2'b01;
    localparam logic [1:0] S_MEMORY  = 2'b10;

    localparam logic [2:0] OP_LDST = 3'b110;
    localparam logic [2:0] OP_BCC  = 3'b111;
    localparam logic [2:0] FN_ADD  = 3'b000;
    localparam logic [2:0] REG_PC  = 3'd7;

    logic [1:0] r_state;
    logic [3:0] r_cc;

    logic [1:0] w_next_state;
    logic [2:0] w_op;
    logic       w_type;
    logic       w_s;
    logic [2:0] w_dst;
    logic [2:0] w_srca;
    logic [2:0] w_srcb;
    logic [1:0] w_shift;
    logic [3:0] w_cond;
    logic       w_is_ldst;
    logic       w_is_st;
    logic       w_is_bcc;
    logic       w_is_alu;
    logic       w_n;
    logic       w_z;
    logic       w_v;
    logic       w_c;
    logic       w_nv;
    logic       w_cond_true;
    logic       w_cc_we;

    // Instruction field extraction and instruction class flags.
    always_comb begin
        w_op      = ir[15:13];
        w_type    = ir[12];
        w_s       = ir[11];
        w_dst     = ir[10:8];
        w_srca    = ir[7:5];
        w_srcb    = ir[4:2];
        w_shift   = ir[1:0];
        w_cond    = ir[11:8];
        w_is_ldst = (w_op == OP_LDST);
        w_is_bcc  = (w_op == OP_BCC);
        w_is_st   = w_is_ldst & ir[11];
        w_is_alu  = ~w_is_ldst & ~w_is_bcc;
    end

    // Branch condition from the registered CC, never the live ALU flags.
    always_comb begin
        w_n         = r_cc[3];
        w_z         = r_cc[2];
        w_v         = r_cc[1];
        w_c         = r_cc[0];
        w_nv        = w_n ^ w_v;
        w_cond_true = 1'b0;
        case (w_cond)
            4'h0: w_cond_true = 1'b1;
            4'h1: w_cond_true = 1'b0;
            4'h2: w_cond_true = ~w_c & ~w_z;
            4'h3: w_cond_true = w_c | w_z;
            4'h4: w_cond_true = ~w_c;
            4'h5: w_cond_true = w_c;
            4'h6: w_cond_true = ~w_z;
            4'h7: w_cond_true = w_z;
            4'h8: w_cond_true = ~w_v;
            4'h9: w_cond_true = w_v;
            4'hA: w_cond_true = ~w_n;
            4'hB: w_cond_true = w_n;
            4'hC: w_cond_true = ~w_nv;
            4'hD: w_cond_true = w_nv;
            4'hE: w_cond_true = ~w_z & ~w_nv;
            4'hF: w_cond_true = w_z | w_nv;
            default: w_cond_true = 1'b0;
        endcase
    end

    // Sequencer next state; LD/ST take the extra MEMORY cycle.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:   w_next_state = S_EXECUTE;
            S_EXECUTE: w_next_state = w_is_ldst ? S_MEMORY : S_FETCH;
            S_MEMORY:  w_next_state = S_FETCH;
            default:   w_next_state = S_FETCH;
        endcase
    end

    // State register; reset wins over any state including MEMORY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Only flag-setting ALU ops in EXECUTE may load the CC register.
    always_comb begin
        w_cc_we = ~rst & (r_state == S_EXECUTE) & w_is_alu & w_s;
    end

    // CC register, loaded from the ALU flags at the end of EXECUTE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cc <= CC_RESET;
        end else if (w_cc_we) begin
            r_cc <= flags_in;
        end
    end

    // Datapath selects: ALU function, operand muxes and register ports.
    always_comb begin
        func     = FN_ADD;
        ext_op   = 1'b0;
        opA_pc   = 1'b0;
        shift_op = 2'b00;
        dest     = w_dst;
        srcA     = w_srca;
        srcB     = w_srcb;
        addr_alu = 1'b0;
        case (r_state)
            S_FETCH: begin
                addr_alu = 1'b0;
            end
            S_EXECUTE: begin
                if (w_is_bcc) begin
                    opA_pc = 1'b1;
                    ext_op = 1'b1;
                    dest   = REG_PC;
                end else begin
                    ext_op   = w_type;
                    shift_op = w_type ? 2'b00 : w_shift;
                    if (w_is_alu) begin
                        func = w_op;
                    end
                end
            end
            S_MEMORY: begin
                addr_alu = 1'b1;
                ext_op   = w_type;
                if (w_is_st) begin
                    srcA = w_dst;
                end
            end
            default: begin
                addr_alu = 1'b0;
            end
        endcase
    end

    // Strobes come from state alone and are held off while in reset.
    always_comb begin
        reg_write = 1'b0;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_ren = 1'b1;
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                end
                S_EXECUTE: begin
                    if (w_is_bcc) begin
                        reg_write = w_cond_true;
                    end else if (w_is_alu) begin
                        reg_write = 1'b1;
                    end
                end
                S_MEMORY: begin
                    if (w_is_st) begin
                        mem_wen = 1'b1;
                    end else begin
                        mem_ren   = 1'b1;
                        reg_write = 1'b1;
                    end
                end
                default: begin
                    reg_write = 1'b0;
                end
            endcase
        end
    end

    assign state = r_state;
    assign cc    = r_cc;
    assign c_in  = r_cc[0];

endmodule

// File: tb/tb_stump_control.sv
// Directed testbench for stump_control with immediate-assertion checks
// and an independent model of the branch condition table.
module tb_stump_control;

    logic        clk;
    logic        rst;
    logic [15:0] ir;
    logic [3:0]  flags_in;
    logic [1:0]  state;
    logic [2:0]  func;
    logic        c_in;
    logic [3:0]  cc;
    logic        ext_op;
    logic        opA_pc;
    logic [2:0]  dest;
    logic [2:0]  srcA;
    logic [2:0]  srcB;
    logic [1:0]  shift_op;
    logic        reg_write;
    logic        ir_load;
    logic        pc_inc;
    logic        mem_ren;
    logic        mem_wen;
    logic        addr_alu;

    int n_vec;
    int n_err;

    stump_control #(.CC_RESET(4'b0000)) dut (
        .clk      (clk),
        .rst      (rst),
        .ir       (ir),
        .flags_in (flags_in),
        .state    (state),
        .func     (func),
        .c_in     (c_in),
        .cc       (cc),
        .ext_op   (ext_op),
        .opA_pc   (opA_pc),
        .dest     (dest),
        .srcA     (srcA),
        .srcB     (srcB),
        .shift_op (shift_op),
        .reg_write(reg_write),
        .ir_load  (ir_load),
        .pc_inc   (pc_inc),
        .mem_ren  (mem_ren),
        .mem_wen  (mem_wen),
        .addr_alu (addr_alu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Loads cc with v through an ADD with S=1; call in FETCH.
    task automatic set_cc(input logic [3:0] v);
        ir = 16'h0A25;
        flags_in = 4'b0000;
        step();
        flags_in = v;
        step();
        flags_in = 4'b0000;
        #1;
    endtask

    // Pairwise formulation: odd codes take the base, even codes invert it.
    function automatic logic cond_model(input logic [3:0] cd,
                                        input logic [3:0] f);
        logic n, z, v, c, b;
        {n, z, v, c} = f;
        case (cd[3:1])
            3'd0: b = 1'b0;
            3'd1: b = c | z;
            3'd2: b = c;
            3'd3: b = z;
            3'd4: b = v;
            3'd5: b = n;
            3'd6: b = n ^ v;
            default: b = z | (n ^ v);
        endcase
        return cd[0] ? b : ~b;
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        ir = 16'h0000;
        flags_in = 4'b0000;
        step();
        step();
        chk("rst_state", 16'(state), 16'h0);
        chk("rst_cc", 16'(cc), 16'h0);
        chk("rst_mem_ren", 16'(mem_ren), 16'h0);
        chk("rst_ir_load", 16'(ir_load), 16'h0);

        rst = 1'b0;
        ir = 16'h0A25;
        #1;
        chk("fetch_mem_ren", 16'(mem_ren), 16'h1);
        chk("fetch_ir_load", 16'(ir_load), 16'h1);
        chk("fetch_pc_inc", 16'(pc_inc), 16'h1);
        chk("fetch_addr_alu", 16'(addr_alu), 16'h0);
        chk("fetch_reg_write", 16'(reg_write), 16'h0);
        chk("fetch_func", 16'(func), 16'h0);

        step();
        flags_in = 4'b0101;
        #1;
        chk("add_state", 16'(state), 16'h1);
        chk("add_func", 16'(func), 16'h0);
        chk("add_shift", 16'(shift_op), 16'h1);
        chk("add_reg_write", 16'(reg_write), 16'h1);
        chk("add_dest", 16'(dest), 16'h2);
        chk("add_srcA", 16'(srcA), 16'h1);
        chk("add_srcB", 16'(srcB), 16'h1);
        chk("add_ext_op", 16'(ext_op), 16'h0);
        chk("add_cc_before", 16'(cc), 16'h0);
        step();
        flags_in = 4'b0000;
        #1;
        chk("add_next_state", 16'(state), 16'h0);
        chk("add_cc_after", 16'(cc), 16'h5);
        chk("add_c_in", 16'(c_in), 16'h1);

        ir = 16'hC3E0;
        step();
        flags_in = 4'b1111;
        #1;
        chk("ld_ex_state", 16'(state), 16'h1);
        chk("ld_ex_reg_write", 16'(reg_write), 16'h0);
        chk("ld_ex_func", 16'(func), 16'h0);
        step();
        chk("ld_mem_state", 16'(state), 16'h2);
        chk("ld_mem_ren", 16'(mem_ren), 16'h1);
        chk("ld_mem_addr_alu", 16'(addr_alu), 16'h1);
        chk("ld_mem_reg_write", 16'(reg_write), 16'h1);
        chk("ld_mem_dest", 16'(dest), 16'h3);
        chk("ld_cc_kept", 16'(cc), 16'h5);
        rst = 1'b1;
        #1;
        chk("rstmem_reg_write", 16'(reg_write), 16'h0);
        chk("rstmem_mem_ren", 16'(mem_ren), 16'h0);
        chk("rstmem_mem_wen", 16'(mem_wen), 16'h0);
        step();
        chk("rstmem_state", 16'(state), 16'h0);
        chk("rstmem_cc", 16'(cc), 16'h0);
        chk("rstmem_ir_load", 16'(ir_load), 16'h0);
        chk("rstmem_pc_inc", 16'(pc_inc), 16'h0);
        step();
        rst = 1'b0;
        #1;
        chk("rel_state", 16'(state), 16'h0);
        chk("rel_ir_load", 16'(ir_load), 16'h1);
        chk("rel_mem_ren", 16'(mem_ren), 16'h1);
        chk("rel_pc_inc", 16'(pc_inc), 16'h1);

        flags_in = 4'b0000;
        step();
        chk("ld2_state1", 16'(state), 16'h1);
        step();
        chk("ld2_state2", 16'(state), 16'h2);
        step();
        chk("ld2_state0", 16'(state), 16'h0);
        chk("ld2_reg_write", 16'(reg_write), 16'h0);

        ir = 16'hCBE0;
        step();
        flags_in = 4'b1111;
        #1;
        chk("st_ex_state", 16'(state), 16'h1);
        chk("st_ex_reg_write", 16'(reg_write), 16'h0);
        step();
        flags_in = 4'b0000;
        #1;
        chk("st_mem_state", 16'(state), 16'h2);
        chk("st_mem_wen", 16'(mem_wen), 16'h1);
        chk("st_mem_ren", 16'(mem_ren), 16'h0);
        chk("st_srcA", 16'(srcA), 16'h3);
        chk("st_reg_write", 16'(reg_write), 16'h0);
        chk("st_addr_alu", 16'(addr_alu), 16'h1);
        chk("st_cc_kept", 16'(cc), 16'h0);
        step();
        chk("st_done_state", 16'(state), 16'h0);

        set_cc(4'b0100);
        ir = 16'hE7FE;
        step();
        chk("beq_t_state", 16'(state), 16'h1);
        chk("beq_t_reg_write", 16'(reg_write), 16'h1);
        chk("beq_t_dest", 16'(dest), 16'h7);
        chk("beq_t_opA_pc", 16'(opA_pc), 16'h1);
        chk("beq_t_ext_op", 16'(ext_op), 16'h1);
        chk("beq_t_func", 16'(func), 16'h0);
        step();
        chk("beq_t_next", 16'(state), 16'h0);

        set_cc(4'b0000);
        ir = 16'hE7FE;
        step();
        chk("beq_f_reg_write", 16'(reg_write), 16'h0);
        chk("beq_f_dest", 16'(dest), 16'h7);
        step();

        for (int v = 0; v < 16; v++) begin
            set_cc(4'(v));
            chk($sformatf("sweep_cc_%0h", v), 16'(cc), 16'(v));
            for (int cd = 0; cd < 16; cd++) begin
                ir = {3'b111, 1'b0, 4'(cd), 8'h00};
                step();
                chk($sformatf("cond_%0h_cc_%0h", cd, v),
                    16'(reg_write),
                    16'(cond_model(4'(cd), 4'(v))));
                step();
            end
        end

        set_cc(4'b1010);
        ir = 16'h3200;
        step();
        flags_in = 4'b1111;
        #1;
        chk("sub_state", 16'(state), 16'h1);
        chk("sub_func", 16'(func), 16'h1);
        chk("sub_ext_op", 16'(ext_op), 16'h1);
        chk("sub_shift", 16'(shift_op), 16'h0);
        chk("sub_reg_write", 16'(reg_write), 16'h1);
        chk("sub_dest", 16'(dest), 16'h2);
        chk("sub_c_in", 16'(c_in), 16'h0);
        step();
        flags_in = 4'b0000;
        #1;
        chk("sub_cc_kept", 16'(cc), 16'hA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stump_control.md
Name: stump_control

Overview:
Control unit for the Stump 16-bit datapath, sitting on the opposite side of the ALU interface. It decodes the instruction register and drives the ALU function code, carry-in, operand selection and register/memory strobes. It also consumes the ALU's {N,Z,V,C} flags into the condition-code (CC) register and evaluates branch conditions. A three-state FETCH/EXECUTE/MEMORY sequencer paces the datapath.

Parameters:
- CC_RESET, 4'b0000, CC register value after reset, ordered {N,Z,V,C}.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ir  input  16  current instruction from the instruction register.
- flags_in  input  4  ALU flags {N,Z,V,C}, combinational from the ALU.
- state  output  2  FETCH=2'b00, EXECUTE=2'b01, MEMORY=2'b10.
- func  output  3  ALU function code.
- c_in  output  1  ALU carry-in, equal to cc[0].
- cc  output  4  CC register {N,Z,V,C}.
- ext_op  output  1  1 selects the sign-extended immediate as operand B.
- opA_pc  output  1  1 selects PC as operand A (branch).
- dest  output  3  register-file write address.
- srcA  output  3  register-file read port A.
- srcB  output  3  register-file read port B.
- shift_op  output  2  shifter control ir[1:0]; 2'b00 in immediate form.
- reg_write  output  1  register-file write enable.
- ir_load  output  1  latch the memory data into IR.
- pc_inc  output  1  increment PC.
- mem_ren  output  1  memory read.
- mem_wen  output  1  memory write.
- addr_alu  output  1  1 puts the ALU result on the address bus, 0 puts PC on it.

Behaviour:
Instruction decode fields:
- op = ir[15:13]; type = ir[12] (0 = register/register, 1 = immediate); S = ir[11]; dst = ir[10:8]; srcA field = ir[7:5]; srcB field = ir[4:2].
- Branch: cond = ir[11:8].
- LD/ST (op 110): ir[11]=0 is LD, 1 is ST.

Reset:
- rst=1 at a clock edge forces state=FETCH and cc=CC_RESET, regardless of the current state, including mid-MEMORY.
- All strobes (reg_write, ir_load, pc_inc, mem_ren, mem_wen, cc update) are combinational from state and must be 0 during any cycle in which rst=1.

Sequencing:
- FETCH -> EXECUTE always.
- EXECUTE -> MEMORY if op==110, else -> FETCH.
- MEMORY -> FETCH.
- Instruction cost: 2 cycles, or 3 for LD/ST.

FETCH:
- mem_ren=1, addr_alu=0, ir_load=1, pc_inc=1.
- All other strobes are 0; func=000.

EXECUTE:
- func = op for op 000..101; func = 000 (ADD) for op 110 and 111.
- ext_op = type; shift_op = type ? 00 : ir[1:0].
- srcA = ir[7:5]; srcB = ir[4:2].
- dest = dst, except branch, where dest = 3'd7.
- Op 000..101: reg_write=1.
- Op 110: reg_write=0 (address computed only).
- Op 111: opA_pc=1, ext_op=1 (8-bit offset ir[7:0] sign-extended by the datapath); reg_write = cond_true.
- CC update: if S=1 and op is 000..101, cc <= flags_in at the end of EXECUTE. Never for op 110/111.

MEMORY:
- addr_alu=1; func=000; no CC update.
- LD: mem_ren=1, reg_write=1, dest = ir[10:8].
- ST: mem_wen=1, srcA = ir[10:8] so the store data is read from port A.

Condition evaluation (uses the registered cc, never flags_in), by cond value:
- 0 always; 1 never.
- 2 HI: !C&!Z. 3 LS: C|Z.
- 4 CC: !C. 5 CS: C.
- 6 NE: !Z. 7 EQ: Z.
- 8 VC: !V. 9 VS: V.
- A PL: !N. B MI: N.
- C GE: N==V. D LT: N!=V.
- E GT: !Z&(N==V). F LE: Z|(N!=V).

Boundary and ordering rules:
- c_in always equals cc[0], so ADC/SBC see the carry produced by the previous flag-setting instruction.
- A branch in the cycle immediately after a flag-setting instruction sees the updated cc.
- Undefined states (2'b11) return to FETCH on the next edge with all strobes 0.

Test Plan:
1. Assert rst for 2 cycles mid-MEMORY of an LD -> state=00, cc=0000, mem_ren/mem_wen/reg_write low during reset cycles; FETCH strobes appear in the first cycle after release.
2. ir=16'h0A25 (ADD, S=1, reg form, dst=2, srcA=1, srcB=1, shift=01) with flags_in=4'b0101 in EXECUTE -> func=000, shift_op=01, reg_write=1, dest=2; cc=0101 next cycle; c_in=1.
3. ir=16'hC3E0 (LD, dst=3) -> states 00,01,10,00; EXECUTE reg_write=0; MEMORY mem_ren=1, addr_alu=1, reg_write=1, dest=3.
4. ir=16'hCBE0 (ST) -> MEMORY mem_wen=1, srcA=3, reg_write=0.
5. Set cc=0100, then ir=16'hE7FE (BEQ) -> EXECUTE reg_write=1, dest=7, opA_pc=1, func=000. With cc=0000 -> reg_write=0.
6. Sweep all 16 cond codes against all 16 cc values -> reg_write in EXECUTE matches the condition table. ir=16'h3200 (SUB, S=0) -> cc unchanged.
